// File: rtl/vga_score_display_if.sv
// rtl/vga_score_display_if.sv - VGA timing, score inputs and RGB outputs of the score renderer.
interface vga_score_display_if #(
  parameter int N_DIGITS = 1
);
  logic [9:0]            h_cnt;
  logic [9:0]            v_cnt;
  logic                  valid;
  logic                  vsync;
  logic [4*N_DIGITS-1:0] score0;
  logic [4*N_DIGITS-1:0] score1;
  logic [3:0]            vgaRed;
  logic [3:0]            vgaGreen;
  logic [3:0]            vgaBlue;

  modport master (
    output h_cnt, v_cnt, valid, vsync, score0, score1,
    input  vgaRed, vgaGreen, vgaBlue
  );

  modport slave (
    input  h_cnt, v_cnt, valid, vsync, score0, score1,
    output vgaRed, vgaGreen, vgaBlue
  );
endinterface

// File: rtl/vga_score_display.sv
// rtl/vga_score_display.sv - two-player seven-segment BCD score overlay, 2-stage pixel pipeline.
module vga_score_display #(
  parameter int          N_DIGITS     = 1,
  parameter int          X_P1         = 275,
  parameter int          X_P0         = 340,
  parameter int          Y0           = 190,
  parameter int          DIG_W        = 50,
  parameter int          DIG_H        = 90,
  parameter int          SEG_W        = 10,
  parameter int          DIG_GAP      = 15,
  parameter logic [11:0] FG_COLOR     = 12'hfff,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] FLASH_COLOR  = 12'hf00,
  parameter int          FLASH_FRAMES = 60,
  parameter int          BLINK_BIT    = 3,
  parameter int          LZ_BLANK     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vga_score_display_if.slave    bus
);

  localparam int SW    = 4 * N_DIGITS;
  localparam int PITCH = DIG_W + DIG_GAP;
  localparam int FW    = $clog2(FLASH_FRAMES + 1);
  localparam int LXW   = $clog2(DIG_W + 1);
  localparam int LYW   = $clog2(DIG_H + 1);

  logic          r_vsync_d;
  logic [SW-1:0] r_lat0, r_lat1;
  logic [FW-1:0] r_flash0, r_flash1;
  logic          w_frame_tick;

  assign w_frame_tick = r_vsync_d & ~bus.vsync;

  // Scores are only sampled on the vsync falling edge so digits never tear mid-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b1;
      r_lat0    <= '0;
      r_lat1    <= '0;
      r_flash0  <= '0;
      r_flash1  <= '0;
    end else begin
      r_vsync_d <= bus.vsync;
      if (w_frame_tick) begin
        r_lat0 <= bus.score0;
        r_lat1 <= bus.score1;
        if (bus.score0 != r_lat0)   r_flash0 <= FW'(FLASH_FRAMES);
        else if (r_flash0 != '0)    r_flash0 <= r_flash0 - FW'(1);
        if (bus.score1 != r_lat1)   r_flash1 <= FW'(FLASH_FRAMES);
        else if (r_flash1 != '0)    r_flash1 <= r_flash1 - FW'(1);
      end
    end
  end

  function automatic int f_x0(input int p, input int k);
    return ((p == 0) ? X_P0 : X_P1) + k * PITCH;
  endfunction

  // Nibble for digit k (0 = MSD); 4'hF stands for a leading-zero blank.
  function automatic logic [3:0] f_nib(input logic [SW-1:0] s, input int k);
    logic       lead;
    logic [3:0] n;
    lead = 1'b1;
    for (int j = 0; j < N_DIGITS; j++)
      if (j <= k && s[4*(N_DIGITS-1-j) +: 4] != 4'h0) lead = 1'b0;
    n = s[4*(N_DIGITS-1-k) +: 4];
    if (LZ_BLANK != 0 && lead && k != N_DIGITS - 1) n = 4'hF;
    return n;
  endfunction

  logic           w_hit, w_player;
  logic [LXW-1:0] w_lx;
  logic [LYW-1:0] w_ly;
  logic [3:0]     w_nib;
  int             w_h, w_v;

  always_comb begin
    w_hit    = 1'b0;
    w_player = 1'b0;
    w_lx     = '0;
    w_nib    = 4'hF;
    w_h      = int'(bus.h_cnt);
    w_v      = int'(bus.v_cnt) - Y0;
    w_ly     = LYW'(w_v);
    // Player 1 is scanned first so an overlapping player-0 hit overrides it.
    for (int p = 1; p >= 0; p--) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (w_v >= 0 && w_v < DIG_H && w_h >= f_x0(p, k) && w_h < f_x0(p, k) + DIG_W) begin
          w_hit    = 1'b1;
          w_player = (p != 0);
          w_lx     = LXW'(w_h - f_x0(p, k));
          w_nib    = (p == 0) ? f_nib(r_lat0, k) : f_nib(r_lat1, k);
        end
      end
    end
  end

  logic           r_s1_valid, r_s1_hit, r_s1_player;
  logic [LXW-1:0] r_s1_lx;
  logic [LYW-1:0] r_s1_ly;
  logic [3:0]     r_s1_nib;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_hit    <= 1'b0;
      r_s1_player <= 1'b0;
      r_s1_lx     <= '0;
      r_s1_ly     <= '0;
      r_s1_nib    <= '0;
    end else begin
      r_s1_valid  <= bus.valid;
      r_s1_hit    <= w_hit;
      r_s1_player <= w_player;
      r_s1_lx     <= w_lx;
      r_s1_ly     <= w_ly;
      r_s1_nib    <= w_nib;
    end
  end

  int            w_lx2, w_ly2;
  logic [6:0]    w_segs_on, w_pattern;
  logic          w_lit;
  logic [FW-1:0] w_flash;
  logic [11:0]   w_rgb;

  // Segment vectors are ordered {a,b,c,d,e,f,g}.
  always_comb begin
    w_lx2     = int'(r_s1_lx);
    w_ly2     = int'(r_s1_ly);
    w_segs_on = {
      (w_ly2 < SEG_W),
      (w_lx2 >= DIG_W - SEG_W && w_ly2 <  DIG_H / 2),
      (w_lx2 >= DIG_W - SEG_W && w_ly2 >= DIG_H / 2),
      (w_ly2 >= DIG_H - SEG_W),
      (w_lx2 <  SEG_W && w_ly2 >= DIG_H / 2),
      (w_lx2 <  SEG_W && w_ly2 <  DIG_H / 2),
      (w_ly2 >= (DIG_H - SEG_W) / 2 && w_ly2 < (DIG_H + SEG_W) / 2)
    };
    case (r_s1_nib)
      4'd0:    w_pattern = 7'b1111110;
      4'd1:    w_pattern = 7'b0110000;
      4'd2:    w_pattern = 7'b1101101;
      4'd3:    w_pattern = 7'b1111001;
      4'd4:    w_pattern = 7'b0110011;
      4'd5:    w_pattern = 7'b1011011;
      4'd6:    w_pattern = 7'b1011111;
      4'd7:    w_pattern = 7'b1110000;
      4'd8:    w_pattern = 7'b1111111;
      4'd9:    w_pattern = 7'b1111011;
      default: w_pattern = 7'b0000000;
    endcase
    w_lit   = r_s1_hit && (|(w_pattern & w_segs_on));
    w_flash = r_s1_player ? r_flash1 : r_flash0;
    w_rgb   = BG_COLOR;
    if (!r_s1_valid)            w_rgb = 12'h000;
    else if (w_lit) begin
      if (w_flash == '0)        w_rgb = FG_COLOR;
      else if (!w_flash[BLINK_BIT]) w_rgb = FLASH_COLOR;
    end
  end

  logic [11:0] r_rgb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rgb <= 12'h000;
    else        r_rgb <= w_rgb;
  end

  assign bus.vgaRed   = r_rgb[11:8];
  assign bus.vgaGreen = r_rgb[7:4];
  assign bus.vgaBlue  = r_rgb[3:0];

endmodule

// File: tb/tb_vga_score_display.sv
// tb/tb_vga_score_display.sv - self-checking bench for vga_score_display (two-digit groups).
module tb_vga_score_display;
  localparam int N   = 2;
  localparam int XP1 = 150;
  localparam int XP0 = 340;
  localparam int Y0  = 190;
  localparam int DW  = 50;
  localparam int DH  = 90;
  localparam int SW  = 10;
  localparam int GAP = 15;
  localparam int FF  = 60;
  localparam int BB  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_score_display_if #(.N_DIGITS(N)) bus ();

  vga_score_display #(
    .N_DIGITS(N), .X_P1(XP1), .X_P0(XP0), .Y0(Y0), .DIG_W(DW), .DIG_H(DH),
    .SEG_W(SW), .DIG_GAP(GAP), .FG_COLOR(12'hfff), .BG_COLOR(12'h000),
    .FLASH_COLOR(12'hf00), .FLASH_FRAMES(FF), .BLINK_BIT(BB), .LZ_BLANK(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Reference state: latched score and remaining flash frames per player.
  logic [7:0] m_lat [2];
  int         m_fl  [2];
  string      seg_tbl [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                               "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic logic [11:0] model_rgb(input int h, input int v, input bit vld);
    logic [11:0] res;
    bit          done, lit, lead;
    int          x0, lx, ly, nib;
    string       px, s;
    res  = 12'h000;
    done = 0;
    if (vld) begin
      for (int p = 0; p < 2; p++) begin
        for (int k = 0; k < N; k++) begin
          x0 = ((p == 0) ? XP0 : XP1) + k * (DW + GAP);
          if (!done && h >= x0 && h < x0 + DW && v >= Y0 && v < Y0 + DH) begin
            done = 1;
            lx   = h - x0;
            ly   = v - Y0;
            nib  = int'((m_lat[p] >> (4 * (N - 1 - k))) & 8'h0f);
            lead = (k < N - 1) && ((m_lat[p] >> (4 * (N - 1 - k))) == 8'h00);
            if (nib <= 9 && !lead) begin
              px = "";
              if (ly < SW)                          px = {px, "a"};
              if (lx >= DW - SW && ly < DH / 2)     px = {px, "b"};
              if (lx >= DW - SW && ly >= DH / 2)    px = {px, "c"};
              if (ly >= DH - SW)                    px = {px, "d"};
              if (lx < SW && ly >= DH / 2)          px = {px, "e"};
              if (lx < SW && ly < DH / 2)           px = {px, "f"};
              if (ly >= (DH - SW) / 2 && ly < (DH + SW) / 2) px = {px, "g"};
              s   = seg_tbl[nib];
              lit = 0;
              for (int i = 0; i < px.len(); i++)
                for (int j = 0; j < s.len(); j++)
                  if (px[i] == s[j]) lit = 1;
              if (lit) begin
                if (m_fl[p] == 0)                         res = 12'hfff;
                else if (((m_fl[p] / (2 ** BB)) % 2) == 1) res = 12'h000;
                else                                      res = 12'hf00;
              end
            end
          end
        end
      end
    end
    return res;
  endfunction

  task automatic do_tick();
    logic [7:0] sc;
    @(posedge clk); #1;
    bus.vsync = 1'b0;
    for (int p = 0; p < 2; p++) begin
      sc = (p == 0) ? bus.score0 : bus.score1;
      if (sc != m_lat[p])   m_fl[p] = FF;
      else if (m_fl[p] > 0) m_fl[p] = m_fl[p] - 1;
      m_lat[p] = sc;
    end
    @(posedge clk);
    @(posedge clk); #1;
    bus.vsync = 1'b1;
  endtask

  task automatic settle();
    repeat (FF + 1) do_tick();
  endtask

  task automatic pix(input int h, input int v, input bit vld, output logic [11:0] rgb);
    @(posedge clk); #1;
    bus.h_cnt = h[9:0];
    bus.v_cnt = v[9:0];
    bus.valid = vld;
    @(posedge clk);
    @(posedge clk); #1;
    rgb = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
  endtask

  task automatic test_reset();
    logic [11:0] got;
    int          pts [3][3] = '{'{350, 195, 12'h000}, '{415, 195, 12'hfff}, '{225, 195, 12'hfff}};
    bus.h_cnt = 10'd415; bus.v_cnt = 10'd195; bus.valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    got = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want 000", got);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pix(pts[i][0], pts[i][1], 1'b1, got);
      tests_run++;
      if (got !== pts[i][2][11:0]) begin
        tests_failed++;
        $display("FAIL reset_state (%0d,%0d): got %h want %h", pts[i][0], pts[i][1], got, pts[i][2][11:0]);
      end
    end
  endtask

  task automatic test_steady();
    logic [11:0] got, exp;
    int          h, v;
    int          pts [4][3] = '{'{450, 250, 12'hfff}, '{430, 235, 12'h000},
                                 '{430, 195, 12'hfff}, '{350, 195, 12'h000}};
    bus.score0 = 8'h07;
    do_tick();
    settle();
    for (int i = 0; i < 4; i++) begin
      pix(pts[i][0], pts[i][1], 1'b1, got);
      tests_run++;
      if (got !== pts[i][2][11:0]) begin
        tests_failed++;
        $display("FAIL steady (%0d,%0d): got %h want %h", pts[i][0], pts[i][1], got, pts[i][2][11:0]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(460, 335);
      v = $urandom_range(285, 185);
      pix(h, v, 1'b1, got);
      exp = model_rgb(h, v, 1'b1);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL steady_rand (%0d,%0d): got %h want %h", h, v, got, exp);
      end
    end
  endtask

  task automatic test_frame_sampling();
    logic [11:0] got;
    bus.score1 = 8'h03;
    do_tick();
    settle();
    pix(225, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'hfff) begin
      tests_failed++;
      $display("FAIL frame_before: got %h want fff", got);
    end
    bus.score1 = 8'h04;
    repeat (20) @(posedge clk);
    pix(225, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'hfff) begin
      tests_failed++;
      $display("FAIL frame_midframe: got %h want fff", got);
    end
    do_tick();
    pix(225, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL frame_after: got %h want 000", got);
    end
  endtask

  task automatic test_flash();
    logic [11:0] got, exp;
    bus.score0 = 8'h02;
    do_tick();
    settle();
    bus.score0 = 8'h03;
    do_tick();
    pix(430, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL flash_first_frame: got %h want 000", got);
    end
    for (int f = 0; f <= FF; f++) begin
      pix(430, 195, 1'b1, got);
      exp = model_rgb(430, 195, 1'b1);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL flash_frame %0d (cnt %0d): got %h want %h", f, m_fl[0], got, exp);
      end
      pix(225, 195, 1'b1, got);
      exp = model_rgb(225, 195, 1'b1);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL flash_other_player %0d: got %h want %h", f, got, exp);
      end
      do_tick();
    end
    pix(430, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'hfff) begin
      tests_failed++;
      $display("FAIL flash_done: got %h want fff", got);
    end
  endtask

  task automatic test_leading_zero();
    logic [11:0] got;
    logic [7:0]  scores [3] = '{8'h05, 8'h00, 8'h50};
    int          pts [3][3][3] = '{
      '{'{350, 195, 12'h000}, '{430, 195, 12'hfff}, '{410, 250, 12'h000}},
      '{'{350, 195, 12'h000}, '{430, 195, 12'hfff}, '{410, 250, 12'hfff}},
      '{'{350, 195, 12'hfff}, '{385, 250, 12'hfff}, '{410, 250, 12'hfff}}};
    for (int s = 0; s < 3; s++) begin
      bus.score0 = scores[s];
      do_tick();
      settle();
      for (int i = 0; i < 3; i++) begin
        pix(pts[s][i][0], pts[s][i][1], 1'b1, got);
        tests_run++;
        if (got !== pts[s][i][2][11:0]) begin
          tests_failed++;
          $display("FAIL lz score %h (%0d,%0d): got %h want %h", scores[s],
                   pts[s][i][0], pts[s][i][1], got, pts[s][i][2][11:0]);
        end
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [11:0] got;
    int          h, v;
    bus.score0 = 8'h0C;
    do_tick();
    settle();
    for (int i = 0; i < 25; i++) begin
      h = $urandom_range(XP0 + DW + GAP + DW - 1, XP0);
      v = $urandom_range(Y0 + DH - 1, Y0);
      pix(h, v, 1'b1, got);
      tests_run++;
      if (got !== 12'h000) begin
        tests_failed++;
        $display("FAIL bcd_C (%0d,%0d): got %h want 000", h, v, got);
      end
    end
    bus.score0 = 8'hC5;
    do_tick();
    settle();
    for (int i = 0; i < 10; i++) begin
      h = $urandom_range(XP0 + DW - 1, XP0);
      v = $urandom_range(Y0 + DH - 1, Y0);
      pix(h, v, 1'b1, got);
      tests_run++;
      if (got !== 12'h000) begin
        tests_failed++;
        $display("FAIL bcd_C_msd (%0d,%0d): got %h want 000", h, v, got);
      end
    end
    pix(430, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'hfff) begin
      tests_failed++;
      $display("FAIL bcd_5_lsd: got %h want fff", got);
    end
    pix(430, 195, 1'b0, got);
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL valid_low: got %h want 000", got);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] q [$];
    logic [11:0] got, exp;
    int          h, v, n;
    bit          vld;
    n = 150;
    bus.score1 = 8'h27;
    bus.score0 = 8'h19;
    for (int fr = 0; fr < 12; fr++) begin
      do_tick();
      if (fr == 6) bus.score0 = 8'h20;
      for (int i = 0; i < n + 2; i++) begin
        @(posedge clk); #1;
        if (i >= 2) begin
          got = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
          exp = q.pop_front();
          tests_run++;
          if (got !== exp) begin
            tests_failed++;
            $display("FAIL b2b frame %0d pix %0d: got %h want %h", fr, i - 2, got, exp);
          end
        end
        if (i < n) begin
          h   = $urandom_range(470, 140);
          v   = $urandom_range(290, 180);
          vld = ($urandom_range(9, 0) != 0);
          bus.h_cnt = h[9:0];
          bus.v_cnt = v[9:0];
          bus.valid = vld;
          q.push_back(model_rgb(h, v, vld));
        end else begin
          bus.valid = 1'b0;
        end
      end
    end
  endtask

  task automatic test_reset_mid_flash();
    logic [11:0] got;
    int          pts [4][3] = '{'{430, 195, 12'hfff}, '{350, 195, 12'h000},
                                 '{410, 250, 12'hfff}, '{225, 195, 12'hfff}};
    bus.score0 = 8'h08;
    do_tick();
    repeat (5) do_tick();
    pix(430, 195, 1'b1, got);
    tests_run++;
    if (got !== 12'hf00) begin
      tests_failed++;
      $display("FAIL midflash_visible (cnt %0d): got %h want f00", m_fl[0], got);
    end
    #3 rst_n = 1'b0;
    #1;
    got = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
    tests_run++;
    if (got !== 12'h000) begin
      tests_failed++;
      $display("FAIL async_reset: got %h want 000", got);
    end
    for (int p = 0; p < 2; p++) begin
      m_lat[p] = 8'h00;
      m_fl[p]  = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(pts[i][0], pts[i][1], 1'b1, got);
      tests_run++;
      if (got !== pts[i][2][11:0]) begin
        tests_failed++;
        $display("FAIL after_reset (%0d,%0d): got %h want %h", pts[i][0], pts[i][1], got, pts[i][2][11:0]);
      end
    end
  endtask

  initial begin
    bus.h_cnt  = '0;
    bus.v_cnt  = '0;
    bus.valid  = 1'b0;
    bus.vsync  = 1'b1;
    bus.score0 = '0;
    bus.score1 = '0;
    for (int p = 0; p < 2; p++) begin
      m_lat[p] = 8'h00;
      m_fl[p]  = 0;
    end
    test_reset();
    test_steady();
    test_frame_sampling();
    test_flash();
    test_leading_zero();
    test_invalid_bcd();
    test_back_to_back();
    test_reset_mid_flash();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
